bcd_stopwatch_ctrl: RTL and testbench

Run/pause/clear controller and cascade sequencer for a chain of decimal (BCD) digit counters. It turns single-cycle start/stop/clear/lap commands into a four-state control FSM. It generates the count tick from a clock prescaler and ripples carries across DIGITS BCD digits. It also captures lap snapshots. It sits between the front-panel command logic and the display/BCD-digit datapath.

---
 rtl/bcd_stopwatch_ctrl.sv | 149 ++++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch_ctrl
// Description : Run/pause/clear/lap control FSM, count-tick prescaler and
//               single-edge carry cascade for a chain of BCD digit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10,
  parameter int WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   lap_value,
  output logic                  lap_valid,
  output logic                  running,
  output logic [1:0]            state,
  output logic                  overflow
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   lap_value_q, lap_value_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            lap_valid_q, lap_valid_d;
  logic            overflow_q, overflow_d;

  logic            tick;
  logic [DIGITS:0] carry;
  logic [CW-1:0]   count_inc;

  // A tick completes only while running; a same-cycle stop or clear cancels it.
  assign tick     = (state_q == RUN) && !clear && !stop && (presc_q == PRESC_LAST);
  assign carry[0] = tick;

  // Carry ripples combinationally so every digit settles on the tick edge.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic is_nine;
    assign is_nine                = (count_q[4*i +: 4] == 4'd9);
    assign carry[i+1]             = carry[i] & is_nine;
    assign count_inc[4*i +: 4]    = !carry[i] ? count_q[4*i +: 4] :
                                    is_nine   ? 4'd0 : count_q[4*i +: 4] + 4'd1;
  end

  // Next-state, prescaler, count, overflow and lap capture; clear dominates.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_d     = presc_q;
    overflow_d  = overflow_q;
    lap_value_d = lap_value_q;
    lap_valid_d = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      count_d    = '0;
      presc_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Snapshot uses the pre-edge count, so a coincident tick is not seen.
      if (lap && (state_q == RUN || state_q == PAUSED)) begin
        lap_value_d = count_q;
        lap_valid_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (stop) begin
            // Prescaler freezes so partial tick time survives the pause.
            state_d = PAUSED;
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
              if (carry[DIGITS]) begin
                overflow_d = 1'b1;
                if (WRAP != 0) begin
                  count_d = count_inc;
                end else begin
                  state_d = DONE;
                end
              end else begin
                count_d = count_inc;
              end
            end
          end
        end
        PAUSED: begin
          if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          // DONE is left only through clear or reset.
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      presc_q     <= '0;
      overflow_q  <= 1'b0;
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      overflow_q  <= overflow_d;
      lap_value_q <= lap_value_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign count     = count_q;
  assign lap_value = lap_value_q;
  assign lap_valid = lap_valid_q;
  assign overflow  = overflow_q;
  assign state     = state_q;
  assign running   = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_stopwatch_ctrl
// Description : Directed self-checking bench for bcd_stopwatch_ctrl
//               (DIGITS=2, TICK_DIV=3; one wrapping and one halting instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, clear, lap;
  logic [7:0] count, lap_value;
  logic       lap_valid, running, overflow;
  logic [1:0] state;

  logic       h_start, h_stop, h_clear, h_lap;
  logic [7:0] h_count, h_lap_value;
  logic       h_lap_valid, h_running, h_overflow;
  logic [1:0] h_state;

  int checks = 0;
  int errors = 0;

  bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(3), .WRAP(1)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count), .lap_value(lap_value), .lap_valid(lap_valid),
    .running(running), .state(state), .overflow(overflow)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(3), .WRAP(0)) u_dut_halt (
    .clk(clk), .rst_n(rst_n), .start(h_start), .stop(h_stop), .clear(h_clear), .lap(h_lap),
    .count(h_count), .lap_value(h_lap_value), .lap_valid(h_lap_valid),
    .running(h_running), .state(h_state), .overflow(h_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; every cycle the wrapping
  // counter must show only legal BCD nibbles.
  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("bcd_nibbles", {31'd0, (count[3:0] <= 4'd9) && (count[7:4] <= 4'd9)}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; clear = 0; lap = 0;
    h_start = 0; h_stop = 0; h_clear = 0; h_lap = 0;
    #12;
    check("rst_count",     {24'd0, count},     32'h00);
    check("rst_state",     {30'd0, state},     32'd0);
    check("rst_running",   {31'd0, running},   32'd0);
    check("rst_lap_value", {24'd0, lap_value}, 32'h00);
    check("rst_lap_valid", {31'd0, lap_valid}, 32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start: first increment TICK_DIV edges after start is sampled.
    start = 1; cyc_n(1); start = 0;                  // edge 0
    check("start_state",   {30'd0, state},   32'd1);
    check("start_running", {31'd0, running}, 32'd1);
    cyc_n(2);                                         // edge 2
    check("edge2_count",   {24'd0, count},   32'h00);
    cyc_n(1);                                         // edge 3
    check("edge3_count",   {24'd0, count},   32'h01);
    cyc_n(3);                                         // edge 6
    check("edge6_count",   {24'd0, count},   32'h02);
    check("edge6_running", {31'd0, running}, 32'd1);

    // Carry into the tens digit, then wrap through all-9s.
    cyc_n(21);
    check("count_09", {24'd0, count}, 32'h09);
    cyc_n(3);
    check("count_10", {24'd0, count}, 32'h10);
    cyc_n(267);
    check("count_99",    {24'd0, count},    32'h99);
    check("ovf_pre",     {31'd0, overflow}, 32'd0);
    cyc_n(3);
    check("wrap_count",  {24'd0, count},    32'h00);
    check("wrap_ovf",    {31'd0, overflow}, 32'd1);
    check("wrap_state",  {30'd0, state},    32'd1);

    // Clear from RUN drops overflow and returns to IDLE.
    clear = 1; cyc_n(1); clear = 0;
    check("clr_state", {30'd0, state},    32'd0);
    check("clr_count", {24'd0, count},    32'h00);
    check("clr_ovf",   {31'd0, overflow}, 32'd0);

    // Halting instance: run to all-9s, then into DONE.
    h_start = 1; cyc_n(1); h_start = 0;
    cyc_n(297);
    check("h_count_99", {24'd0, h_count}, 32'h99);
    check("h_state_run", {30'd0, h_state}, 32'd1);
    cyc_n(3);
    check("h_hold_count", {24'd0, h_count},    32'h99);
    check("h_ovf",        {31'd0, h_overflow}, 32'd1);
    check("h_done",       {30'd0, h_state},    32'd3);
    check("h_running",    {31'd0, h_running},  32'd0);
    h_start = 1; cyc_n(1); h_start = 0;
    cyc_n(3);
    check("h_start_ign_state", {30'd0, h_state}, 32'd3);
    check("h_start_ign_count", {24'd0, h_count}, 32'h99);
    h_lap = 1; cyc_n(1); h_lap = 0;
    check("h_lap_done_valid", {31'd0, h_lap_valid}, 32'd0);
    h_clear = 1; cyc_n(1); h_clear = 0;
    check("h_clr_state", {30'd0, h_state},    32'd0);
    check("h_clr_count", {24'd0, h_count},    32'h00);
    check("h_clr_ovf",   {31'd0, h_overflow}, 32'd0);

    // Pause preserves partial tick time.
    start = 1; cyc_n(1); start = 0;                  // prescaler 0
    cyc_n(1);                                         // prescaler 1
    stop = 1; cyc_n(1); stop = 0;
    check("pause_state",   {30'd0, state},   32'd2);
    check("pause_running", {31'd0, running}, 32'd0);
    cyc_n(10);
    check("pause_count", {24'd0, count}, 32'h00);
    start = 1; cyc_n(1); start = 0;                  // resume edge r
    check("resume_state", {30'd0, state}, 32'd1);
    check("resume_count", {24'd0, count}, 32'h00);
    cyc_n(1);
    check("resume_r1",    {24'd0, count}, 32'h00);
    cyc_n(1);
    check("resume_r2",    {24'd0, count}, 32'h01);

    // Lap coinciding with the 0x24 -> 0x25 tick.
    cyc_n(69);
    check("pre_lap_count", {24'd0, count}, 32'h24);
    cyc_n(2);
    lap = 1; cyc_n(1); lap = 0;
    check("lap_tick_count", {24'd0, count},     32'h25);
    check("lap_value_24",   {24'd0, lap_value}, 32'h24);
    check("lap_valid_hi",   {31'd0, lap_valid}, 32'd1);
    cyc_n(1);
    check("lap_valid_lo",   {31'd0, lap_valid}, 32'd0);
    clear = 1; lap = 1; cyc_n(1); clear = 0; lap = 0;
    check("clrlap_valid", {31'd0, lap_valid}, 32'd0);
    check("clrlap_value", {24'd0, lap_value}, 32'h24);
    check("clrlap_state", {30'd0, state},     32'd0);

    // Back-to-back laps give back-to-back pulses.
    start = 1; cyc_n(1); start = 0;
    lap = 1; cyc_n(1);
    check("b2b_valid1", {31'd0, lap_valid}, 32'd1);
    check("b2b_value1", {24'd0, lap_value}, 32'h00);
    cyc_n(1); lap = 0;
    check("b2b_valid2", {31'd0, lap_valid}, 32'd1);
    cyc_n(1);
    check("b2b_valid3", {31'd0, lap_valid}, 32'd0);
    check("b2b_count",  {24'd0, count},     32'h01);

    // All three commands together in RUN: clear wins.
    start = 1; stop = 1; clear = 1; cyc_n(1); start = 0; stop = 0; clear = 0;
    check("all_state",   {30'd0, state},   32'd0);
    check("all_count",   {24'd0, count},   32'h00);
    check("all_running", {31'd0, running}, 32'd0);

    // Asynchronous reset mid-run with a live lap pulse.
    start = 1; cyc_n(1); start = 0;
    cyc_n(3);
    lap = 1; cyc_n(1); lap = 0;
    check("prerst_count", {24'd0, count},     32'h01);
    check("prerst_valid", {31'd0, lap_valid}, 32'd1);
    check("prerst_value", {24'd0, lap_value}, 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",     {24'd0, count},     32'h00);
    check("arst_state",     {30'd0, state},     32'd0);
    check("arst_running",   {31'd0, running},   32'd0);
    check("arst_lap_value", {24'd0, lap_value}, 32'h00);
    check("arst_lap_valid", {31'd0, lap_valid}, 32'd0);
    check("arst_overflow",  {31'd0, overflow},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_n(5);
    check("post_rst_idle", {30'd0, state}, 32'd0);
    check("post_rst_count", {24'd0, count}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
